axi_sram_slave: RTL and testbench

- AXI3 responder that serves read and write transactions from a single-port synchronous SRAM (word-addressed, byte write enables).
- Sits on the slave side of the crossbar. Acts as the memory model and on-chip RAM target for the uncached instruction and data masters.
- Handles one transaction at a time, with burst support and read/write arbitration.

---
 rtl/axi_pkg.sv | 21 ++
 rtl/axi_burst_addr.sv | 22 ++
 rtl/axi_sram_slave.sv | 213 +++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI3 constants and the SRAM responder state type.
// Latency: none (declarations only).
// Backpressure: not applicable.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_RESP,
    WR_DATA,
    WR_RESP
  } state_e;

endpackage

// File: rtl/axi_burst_addr.sv
// Next beat address of an AXI burst from the current address, size and burst type.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to take the new address.
module axi_burst_addr
  import axi_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr
);

  // FIXED holds the address; WRAP (and the reserved code) step like INCR,
  // wrapping naturally at 2^32.
  always_comb begin
    next_addr = addr;
    if (burst != BURST_FIXED) begin
      next_addr = addr + (32'd1 << size);
    end
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 responder serving one burst at a time from a single-port synchronous SRAM.
// Latency: first rvalid 2 cycles after AR handshake (1 beat / 2 cycles); wready 1 cycle after AW.
// Backpressure: rvalid/bvalid hold until rready/bready; W beats accepted only while wvalid is high.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              rstn,
  // read address
  input  logic [ID_W-1:0]   arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  // read data
  output logic [ID_W-1:0]   rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  // write address
  input  logic [ID_W-1:0]   awid,
  input  logic [31:0]       awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awvalid,
  output logic              awready,
  // write data
  input  logic [ID_W-1:0]   wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  // write response
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  // SRAM
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  state_e          state_q, state_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [31:0]     addr_q, addr_d;
  logic [7:0]      len_q, len_d;
  logic [2:0]      size_q, size_d;
  logic [1:0]      burst_q, burst_d;
  logic [7:0]      beat_q, beat_d;
  logic            err_q, err_d;
  logic            prio_rd_q, prio_rd_d;

  logic [31:0]     next_addr;
  logic            grant_rd;
  logic            last_beat;

  // wid carries no information here: responses always use the latched AW id.
  logic unused_wid;
  assign unused_wid = ^wid;

  axi_burst_addr u_burst_addr (
    .addr      (addr_q),
    .size      (size_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  assign last_beat = (beat_q == len_q);

  // Next-state, channel handshakes and SRAM drive for the single active burst.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    err_d     = err_q;
    prio_rd_d = prio_rd_q;

    grant_rd  = 1'b0;
    arready   = 1'b0;
    awready   = 1'b0;
    rvalid    = 1'b0;
    rlast     = 1'b0;
    rid       = id_q;
    rdata     = ram_rdata;
    rresp     = RESP_OKAY;
    wready    = 1'b0;
    bvalid    = 1'b0;
    bid       = id_q;
    bresp     = err_q ? RESP_SLVERR : RESP_OKAY;
    ram_en    = 1'b0;
    ram_wen   = 4'h0;
    ram_addr  = addr_q[ADDR_W+1:2];
    ram_wdata = wdata;

    unique case (state_q)
      IDLE: begin
        // Reads win unless a write is also waiting and it is the write's turn.
        grant_rd = arvalid & (~awvalid | prio_rd_q);
        arready  = arvalid & grant_rd;
        awready  = awvalid & ~grant_rd;
        if (arready) begin
          id_d    = arid;
          addr_d  = araddr;
          len_d   = arlen;
          size_d  = arsize;
          burst_d = arburst;
          beat_d  = 8'd0;
          state_d = RD_REQ;
        end else if (awready) begin
          id_d    = awid;
          addr_d  = awaddr;
          len_d   = awlen;
          size_d  = awsize;
          burst_d = awburst;
          beat_d  = 8'd0;
          err_d   = 1'b0;
          state_d = WR_DATA;
        end
      end

      RD_REQ: begin
        ram_en  = 1'b1;
        state_d = RD_RESP;
      end

      RD_RESP: begin
        // rdata comes straight from the SRAM, which holds it until the next ram_en.
        rvalid = 1'b1;
        rlast  = last_beat;
        if (rready) begin
          if (last_beat) begin
            prio_rd_d = 1'b0;
            state_d   = IDLE;
          end else begin
            addr_d  = next_addr;
            beat_d  = beat_q + 8'd1;
            state_d = RD_REQ;
          end
        end
      end

      WR_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          ram_en  = 1'b1;
          ram_wen = wstrb;
          addr_d  = next_addr;
          if (wlast != last_beat) begin
            err_d = 1'b1;
          end
          if (last_beat) begin
            state_d = WR_RESP;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end

      WR_RESP: begin
        bvalid = 1'b1;
        if (bready) begin
          err_d     = 1'b0;
          prio_rd_d = 1'b1;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and burst context registers; reset drops any burst in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      beat_q    <= '0;
      err_q     <= 1'b0;
      prio_rd_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
      prio_rd_q <= prio_rd_d;
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
module tb_axi_sram_slave;
  localparam int ADDR_W = 12;
  localparam int ID_W   = 4;
  localparam int NW     = 1 << ADDR_W;
  localparam int TMO    = 2000;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [ID_W-1:0] arid = '0, awid = '0, wid = '0, rid, bid;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0, rdata, ram_wdata;
  logic [7:0]  arlen = '0, awlen = '0;
  logic [2:0]  arsize = '0, awsize = '0;
  logic [1:0]  arburst = '0, awburst = '0, rresp, bresp;
  logic arvalid = 0, awvalid = 0, wvalid = 0, wlast = 0, rready = 0, bready = 0;
  logic [3:0]  wstrb = '0, ram_wen;
  logic arready, awready, rvalid, rlast, wready, bvalid, ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0] ram_rdata = '0;

  axi_sram_slave #(.ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
    .clk(clk), .rstn(rstn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // ---------------- SRAM environment (with preload port) ----------------
  logic [31:0] mem [NW] = '{default: 32'h0};
  logic        pl_en = 0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [31:0] pl_data = '0;

  always @(posedge clk) begin
    logic [31:0] w;
    if (pl_en) mem[pl_addr] <= pl_data;
    if (ram_en) begin
      if (ram_wen == 4'h0) ram_rdata <= mem[ram_addr];
      else begin
        w = mem[ram_addr];
        for (int b = 0; b < 4; b++) if (ram_wen[b]) w[8*b +: 8] = ram_wdata[8*b +: 8];
        mem[ram_addr] <= w;
      end
    end
  end

  // ---------------- reference model state ----------------
  typedef struct packed { logic [31:0] data; logic last; logic [ID_W-1:0] id; } rbeat_t;
  logic [31:0] ref_mem [NW] = '{default: 32'h0};
  rbeat_t rexp[$];
  logic [31:0] rlog[$];
  logic [31:0] wq_d[$];
  logic [3:0]  wq_s[$];
  int n_vec = 0, n_err = 0, cyc = 0;
  bit model_prio_rd = 1;
  bit w_act = 0, w_err = 0, b_pend = 0, r_first = 0, w_first = 0;
  logic [31:0] w_addr = '0;
  logic [7:0]  w_len = '0;
  logic [2:0]  w_size = '0;
  logic [1:0]  w_burst = '0;
  logic [ID_W-1:0] w_id = '0, b_id = '0, last_bid = '0;
  logic [1:0]  b_resp = '0, last_bresp = '0;
  int w_beat = 0, ar_cyc = 0, aw_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // byte address of beat i of a burst
  function automatic logic [31:0] addr_at(input logic [31:0] a, input logic [2:0] s,
                                          input logic [1:0] b, input int i);
    if (b == 2'b00) return a;
    return a + (32'(i) << s);
  endfunction

  function automatic logic [31:0] rlog_at(input int i);
    logic [31:0] v;
    v = 'x;
    if (rlog.size() > i) v = rlog[i];
    return v;
  endfunction

  // ---------------- compare process (negedge) ----------------
  always @(negedge clk) begin
    logic [31:0] a;
    logic [31:0] w;
    cyc++;
    if (pl_en) ref_mem[pl_addr] = pl_data;
    if (!rstn) begin
      chk("reset_outputs", {25'd0, arready, awready, rvalid, wready, bvalid, ram_en, |ram_wen}, 32'd0);
      rexp.delete();
      w_act = 0; b_pend = 0; model_prio_rd = 1; r_first = 0; w_first = 0;
    end else begin
      chk("ar_aw_exclusive", {31'd0, arready & awready}, 32'd0);
      if (arvalid && arready) begin
        if (awvalid) chk("arb_read_turn", {31'd0, model_prio_rd}, 32'd1);
        for (int i = 0; i <= int'(arlen); i++) begin
          a = addr_at(araddr, arsize, arburst, i);
          rexp.push_back('{ref_mem[a[ADDR_W+1:2]], (i == int'(arlen)), arid});
        end
        ar_cyc = cyc; r_first = 1;
      end
      if (awvalid && awready) begin
        if (arvalid) chk("arb_write_turn", {31'd0, model_prio_rd}, 32'd0);
        w_act = 1; w_addr = awaddr; w_len = awlen; w_size = awsize; w_burst = awburst;
        w_id = awid; w_beat = 0; w_err = 0; aw_cyc = cyc; w_first = 1;
      end
      if (rvalid) begin
        if (r_first) begin chk("rd_latency", 32'(cyc - ar_cyc), 32'd2); r_first = 0; end
        if (rexp.size() == 0) chk("rvalid_unexpected", 32'd1, 32'd0);
        else begin
          chk("rdata", rdata, rexp[0].data);
          chk("rid", 32'(rid), 32'(rexp[0].id));
          chk("rlast", {31'd0, rlast}, {31'd0, rexp[0].last});
          chk("rresp", 32'(rresp), 32'd0);
          if (rready) begin
            if (rexp[0].last) model_prio_rd = 0;
            rlog.push_back(rdata);
            void'(rexp.pop_front());
          end
        end
      end
      if (wready) begin
        if (w_first) begin chk("wr_latency", 32'(cyc - aw_cyc), 32'd1); w_first = 0; end
        if (!w_act) chk("wready_unexpected", 32'd1, 32'd0);
        else if (wvalid) begin
          a = addr_at(w_addr, w_size, w_burst, w_beat);
          chk("ram_en_wr", {31'd0, ram_en}, 32'd1);
          chk("ram_wen", 32'(ram_wen), 32'(wstrb));
          chk("ram_addr_wr", 32'(ram_addr), 32'(a[ADDR_W+1:2]));
          chk("ram_wdata", ram_wdata, wdata);
          w = ref_mem[a[ADDR_W+1:2]];
          for (int b = 0; b < 4; b++) if (wstrb[b]) w[8*b +: 8] = wdata[8*b +: 8];
          ref_mem[a[ADDR_W+1:2]] = w;
          if (wlast != (w_beat == int'(w_len))) w_err = 1;
          if (w_beat == int'(w_len)) begin
            w_act = 0; b_pend = 1; b_id = w_id; b_resp = w_err ? 2'b10 : 2'b00;
          end
          w_beat++;
        end
      end
      if (bvalid) begin
        if (!b_pend) chk("bvalid_unexpected", 32'd1, 32'd0);
        else begin
          chk("bid", 32'(bid), 32'(b_id));
          chk("bresp", 32'(bresp), 32'(b_resp));
          if (bready) begin
            b_pend = 0; model_prio_rd = 1; last_bid = bid; last_bresp = bresp;
          end
        end
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic preload(input int word, input logic [31:0] d);
    @(posedge clk); #1;
    pl_en = 1; pl_addr = ADDR_W'(word); pl_data = d;
    @(posedge clk); #1;
    pl_en = 0;
  endtask

  task automatic do_read(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input int stall_beat, input int stall_n, input bit rnd);
    int to, beats, stalled;
    bit done;
    @(posedge clk); #1;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1;
    to = 0;
    do begin @(negedge clk); to++; end while (!arready && to < TMO);
    if (!arready) begin chk("ar_timeout", 32'd0, 32'd1); arvalid = 0; return; end
    @(posedge clk); #1;
    arvalid = 0;
    beats = 0; stalled = 0; done = 0; to = 0;
    while (!done && to < TMO) begin
      if (beats == stall_beat && stalled < stall_n) begin
        rready = 0;
        if (rvalid) stalled++;
      end else rready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk); to++;
      if (rvalid && rready) begin beats++; if (rlast) done = 1; end
      @(posedge clk); #1;
    end
    rready = 0;
    if (!done) chk("rd_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_write(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input bit rnd, input int err_beat);
    int to, i;
    bit hs, done;
    @(posedge clk); #1;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1;
    to = 0;
    do begin @(negedge clk); to++; end while (!awready && to < TMO);
    if (!awready) begin chk("aw_timeout", 32'd0, 32'd1); awvalid = 0; return; end
    @(posedge clk); #1;
    awvalid = 0;
    i = 0; to = 0;
    while (i <= int'(len) && to < TMO) begin
      if (!wvalid && (!rnd || $urandom_range(0, 2) != 0)) begin
        wvalid = 1; wid = id;
        wdata = (wq_d.size() > 0) ? wq_d.pop_front() : $urandom;
        wstrb = (wq_s.size() > 0) ? wq_s.pop_front() : 4'($urandom_range(0, 15));
        wlast = (i == int'(len)) || (i == err_beat);
      end
      @(negedge clk); to++;
      hs = wvalid && wready;
      @(posedge clk); #1;
      if (hs) begin wvalid = 0; i++; end
    end
    wvalid = 0;
    if (i <= int'(len)) chk("w_timeout", 32'd0, 32'd1);
    done = 0; to = 0;
    while (!done && to < TMO) begin
      bready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk); to++;
      if (bvalid && bready) done = 1;
      @(posedge clk); #1;
    end
    bready = 0;
    if (!done) chk("b_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int to, n;
    repeat (3) @(posedge clk);
    #1 rstn = 1;

    // Arbitration: both pending out of reset -> read first, then write, then read.
    @(posedge clk); #1;
    arid = 1; araddr = 32'h40; arlen = 0; arsize = 2; arburst = 1; arvalid = 1;
    awid = 2; awaddr = 32'h300; awlen = 0; awsize = 2; awburst = 1; awvalid = 1;
    rready = 1; bready = 1;
    @(negedge clk);
    chk("arb0_arready", {31'd0, arready}, 32'd1);
    chk("arb0_awready", {31'd0, awready}, 32'd0);
    to = 0;
    do begin @(negedge clk); to++; end while (!awready && to < TMO);
    chk("arb1_write_after_read", 32'(to), 32'd3);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 1; wid = 2; wdata = 32'h5A5A5A5A; wstrb = 4'hF; wlast = 1;
    @(negedge clk);
    chk("arb1_wready", {31'd0, wready}, 32'd1);
    @(posedge clk); #1;
    wvalid = 0;
    to = 0;
    do begin @(negedge clk); to++; end while (!arready && to < TMO);
    chk("arb2_read_after_write", {31'd0, arready}, 32'd1);
    @(posedge clk); #1;
    arvalid = 0;
    to = 0;
    do begin @(negedge clk); to++; end while (!(rvalid && rlast) && to < TMO);
    @(posedge clk); #1;
    rready = 0; bready = 0;
    chk("arb_write_data", mem[12'hC0], 32'h5A5A5A5A);

    // Single read with exact timing.
    preload(12'h010, 32'hDEADBEEF);
    @(posedge clk); #1;
    arid = 7; araddr = 32'h40; arlen = 0; arsize = 2; arburst = 1; arvalid = 1; rready = 1;
    @(negedge clk);
    chk("sr_arready_T", {31'd0, arready}, 32'd1);
    @(posedge clk); #1;
    arvalid = 0;
    @(negedge clk);
    chk("sr_rvalid_T1", {31'd0, rvalid}, 32'd0);
    @(negedge clk);
    chk("sr_rvalid_T2", {31'd0, rvalid}, 32'd1);
    chk("sr_rdata", rdata, 32'hDEADBEEF);
    chk("sr_rid", 32'(rid), 32'd7);
    chk("sr_rlast", {31'd0, rlast}, 32'd1);
    chk("sr_rresp", 32'(rresp), 32'd0);
    @(posedge clk); #1;
    rready = 0;

    // INCR read burst with a 3-cycle stall on beat 2.
    for (int i = 0; i < 4; i++) preload(12'h040 + i, 32'(i + 1));
    rlog.delete();
    do_read(5, 32'h100, 3, 2, 2'b01, 1, 3, 0);
    for (int i = 0; i < 4; i++) chk("incr_beat", rlog_at(i), 32'(i + 1));

    // Write burst with partial strobe on second beat.
    wq_d = '{32'hAAAA5555, 32'h12345678};
    wq_s = '{4'hF, 4'h3};
    do_write(3, 32'h200, 1, 2, 2'b01, 0, -1);
    chk("wb_word80", mem[12'h080], 32'hAAAA5555);
    chk("wb_word81", mem[12'h081], 32'h00005678);
    chk("wb_bid", 32'(last_bid), 32'd3);
    chk("wb_bresp", 32'(last_bresp), 32'd0);

    // Early wlast -> both beats still written, SLVERR.
    wq_d = '{32'h11111111, 32'h22222222};
    wq_s = '{4'hF, 4'hF};
    do_write(9, 32'h240, 1, 2, 2'b01, 0, 0);
    chk("we_word90", mem[12'h090], 32'h11111111);
    chk("we_word91", mem[12'h091], 32'h22222222);
    chk("we_bresp", 32'(last_bresp), 32'd2);

    // Wrap-around at the top of memory.
    preload(12'hFFF, 32'hCAFEF00D);
    preload(12'h000, 32'h0BADC0DE);
    rlog.delete();
    do_read(2, 32'h3FFC, 1, 2, 2'b01, -1, 0, 0);
    chk("wrap_beat0", rlog_at(0), 32'hCAFEF00D);
    chk("wrap_beat1", rlog_at(1), 32'h0BADC0DE);

    // Full 256-beat INCR read with random rready.
    do_read(1, 32'h800, 8'd255, 2, 2'b01, -1, 0, 1);

    // Reset asserted while beat 2 of a 4-beat read is presented.
    @(posedge clk); #1;
    arid = 6; araddr = 32'h500; arlen = 3; arsize = 2; arburst = 1; arvalid = 1; rready = 1;
    to = 0;
    do begin @(negedge clk); to++; end while (!arready && to < TMO);
    @(posedge clk); #1;
    arvalid = 0;
    n = 0; to = 0;
    while (to < TMO) begin
      @(negedge clk); to++;
      if (rvalid) begin
        if (n == 1) break;
        if (rready) n++;
      end
    end
    chk("rst_mid_reached_beat2", 32'(n), 32'd1);
    #2 rstn = 0;
    #1;
    chk("rst_async_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_async_ram_en", {31'd0, ram_en}, 32'd0);
    rready = 0;
    repeat (3) @(posedge clk);
    #1 rstn = 1;
    @(negedge clk);
    chk("rst_release_idle", {31'd0, rvalid}, 32'd0);
    rlog.delete();
    do_read(4, 32'h40, 0, 2, 2'b01, -1, 0, 0);
    chk("post_rst_beats", 32'(rlog.size()), 32'd1);
    chk("post_rst_data", rlog_at(0), 32'hDEADBEEF);

    // Randomized mix of reads, writes and contending pairs.
    for (int k = 0; k < 60; k++) begin
      int mode;
      logic [ID_W-1:0] rid_s, wid_s;
      logic [31:0] ra, wa;
      logic [7:0] rl, wl;
      logic [2:0] rs, ws;
      logic [1:0] rb, wb;
      int eb;
      mode = $urandom_range(0, 2);
      rid_s = ID_W'($urandom); wid_s = ID_W'($urandom);
      ra = $urandom; wa = $urandom;
      rl = 8'($urandom_range(0, 7)); wl = 8'($urandom_range(0, 7));
      rs = 3'($urandom_range(0, 2)); ws = 3'($urandom_range(0, 2));
      rb = 2'($urandom_range(0, 2)); wb = 2'($urandom_range(0, 2));
      eb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1;
      case (mode)
        0: do_read(rid_s, ra, rl, rs, rb, -1, 0, 1);
        1: do_write(wid_s, wa, wl, ws, wb, 1, eb);
        default: fork
          do_read(rid_s, ra, rl, rs, rb, -1, 0, 1);
          do_write(wid_s, wa, wl, ws, wb, 1, eb);
        join
      endcase
    end

    repeat (4) @(posedge clk);
    #1;
    n = 0;
    for (int i = 0; i < NW; i++) if (mem[i] !== ref_mem[i]) n++;
    chk("mem_image_diffs", 32'(n), 32'd0);
    chk("rexp_drained", 32'(rexp.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
